// File: rtl/alu_op_decoder.sv
// Registered RV32I OP / OP-IMM decode stage feeding the integer ALU.
// Single-entry valid/ready register with flush; one instruction per cycle.
module alu_op_decoder #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] aluSelect,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm,
    output logic             use_imm,
    output logic             reg_write,
    output logic             illegal
);

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [SEL_W-1:0] SEL_ADDI  = SEL_W'(6'b010011);
    localparam logic [SEL_W-1:0] SEL_SLTI  = SEL_W'(6'b010100);
    localparam logic [SEL_W-1:0] SEL_SLTIU = SEL_W'(6'b010101);
    localparam logic [SEL_W-1:0] SEL_XORI  = SEL_W'(6'b010110);
    localparam logic [SEL_W-1:0] SEL_ORI   = SEL_W'(6'b010111);
    localparam logic [SEL_W-1:0] SEL_ANDI  = SEL_W'(6'b011000);
    localparam logic [SEL_W-1:0] SEL_SLLI  = SEL_W'(6'b011001);
    localparam logic [SEL_W-1:0] SEL_SRLI  = SEL_W'(6'b011010);
    localparam logic [SEL_W-1:0] SEL_SRAI  = SEL_W'(6'b011011);
    localparam logic [SEL_W-1:0] SEL_ADD   = SEL_W'(6'b011100);
    localparam logic [SEL_W-1:0] SEL_SLL   = SEL_W'(6'b011101);
    localparam logic [SEL_W-1:0] SEL_SLT   = SEL_W'(6'b011110);
    localparam logic [SEL_W-1:0] SEL_SLTU  = SEL_W'(6'b011111);
    localparam logic [SEL_W-1:0] SEL_XOR   = SEL_W'(6'b100000);
    localparam logic [SEL_W-1:0] SEL_SRL   = SEL_W'(6'b100001);
    localparam logic [SEL_W-1:0] SEL_OR    = SEL_W'(6'b100010);
    localparam logic [SEL_W-1:0] SEL_AND   = SEL_W'(6'b100011);
    localparam logic [SEL_W-1:0] SEL_SUB   = SEL_W'(6'b100100);
    localparam logic [SEL_W-1:0] SEL_SRA   = SEL_W'(6'b100101);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  immI;
    logic [XLEN-1:0]  immShamt;
    logic [SEL_W-1:0] decSel;
    logic [XLEN-1:0]  decImm;
    logic [4:0]       decRs2;
    logic             decUseImm;
    logic             decLegal;
    logic             decRegWrite;
    logic             load;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign immI     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign immShamt = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Anything not positively recognised falls through as illegal with a zeroed payload.
    always_comb begin
        decSel    = '0;
        decImm    = '0;
        decRs2    = in_instr[24:20];
        decUseImm = 1'b0;
        decLegal  = 1'b0;
        case (opcode)
            OPC_OPIMM: begin
                decRs2    = '0;
                decUseImm = 1'b1;
                decLegal  = 1'b1;
                decImm    = immI;
                case (funct3)
                    3'b000: decSel = SEL_ADDI;
                    3'b010: decSel = SEL_SLTI;
                    3'b011: decSel = SEL_SLTIU;
                    3'b100: decSel = SEL_XORI;
                    3'b110: decSel = SEL_ORI;
                    3'b111: decSel = SEL_ANDI;
                    3'b001: begin
                        decImm   = immShamt;
                        decSel   = SEL_SLLI;
                        decLegal = (funct7 == F7_BASE);
                    end
                    default: begin
                        decImm   = immShamt;
                        decSel   = (funct7 == F7_ALT) ? SEL_SRAI : SEL_SRLI;
                        decLegal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    decLegal = 1'b1;
                    case (funct3)
                        3'b000:  decSel = SEL_ADD;
                        3'b001:  decSel = SEL_SLL;
                        3'b010:  decSel = SEL_SLT;
                        3'b011:  decSel = SEL_SLTU;
                        3'b100:  decSel = SEL_XOR;
                        3'b101:  decSel = SEL_SRL;
                        3'b110:  decSel = SEL_OR;
                        default: decSel = SEL_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    decLegal = 1'b1;
                    decSel   = SEL_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    decLegal = 1'b1;
                    decSel   = SEL_SRA;
                end
            end
            default: ;
        endcase
        if (!decLegal) begin
            decSel    = '0;
            decImm    = '0;
            decUseImm = 1'b0;
        end
    end

    assign decRegWrite = decLegal && (in_instr[11:7] != 5'd0);

    // Flush beats load; a consume without a new load just drops valid and keeps the payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            aluSelect <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            imm       <= '0;
            use_imm   <= 1'b0;
            reg_write <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            aluSelect <= decSel;
            rs1       <= in_instr[19:15];
            rs2       <= decRs2;
            rd        <= in_instr[11:7];
            imm       <= decImm;
            use_imm   <= decUseImm;
            reg_write <= decRegWrite;
            illegal   <= !decLegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench for alu_op_decoder: directed scenarios plus a randomized
// run against a table-driven decode model and a one-deep expected queue.
module tb_alu_op_decoder;

    typedef struct packed {
        logic [5:0]  sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        useImm;
        logic        regWrite;
        logic        illegal;
    } Bundle;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  aluSelect;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        illegal;
    Bundle       actB;

    int errors = 0;
    int checks = 0;

    alu_op_decoder #(.XLEN(32), .SEL_W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .aluSelect(aluSelect), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .use_imm(use_imm), .reg_write(reg_write), .illegal(illegal)
    );

    assign actB = {aluSelect, rs1, rs2, rd, imm, use_imm, reg_write, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decode from the ISA tables: OP-IMM uses a funct3 lookup, OP is base code plus funct3.
    function automatic Bundle refDecode(input logic [31:0] i);
        Bundle      b;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       legal;
        int         immSel[8];
        immSel = '{19, 25, 20, 21, 22, 26, 23, 24};
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        legal = 1'b0;
        b = '0;
        b.rs1 = i[19:15];
        b.rd  = i[11:7];
        b.rs2 = i[24:20];
        if (op == 7'h13) begin
            b.rs2 = 5'd0;
            if (f3 == 3'd1) begin
                legal = (f7 == 7'h00);
                b.sel = 6'd25;
                b.imm = {27'd0, i[24:20]};
            end else if (f3 == 3'd5) begin
                legal = (f7 == 7'h00) || (f7 == 7'h20);
                b.sel = (f7 == 7'h20) ? 6'd27 : 6'd26;
                b.imm = {27'd0, i[24:20]};
            end else begin
                legal = 1'b1;
                b.sel = 6'(immSel[f3]);
                b.imm = {{20{i[31]}}, i[31:20]};
            end
        end else if (op == 7'h33) begin
            if (f7 == 7'h00) begin
                legal = 1'b1;
                b.sel = 6'(28 + int'(f3));
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                legal = 1'b1;
                b.sel = (f3 == 3'd0) ? 6'd36 : 6'd37;
            end
        end
        b.useImm = legal && (op == 7'h13);
        if (!legal) begin
            b.sel = '0;
            b.imm = '0;
            b.illegal = 1'b1;
        end
        b.regWrite = legal && (b.rd != 5'd0);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || actB !== Bundle'(0)) begin
            errors++;
            $display("[TB] FAIL reset_outputs valid=%b bundle=%h required valid=0 bundle=0", out_valid, actB);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got=%b required=1", in_ready);
        end
        tick();
    endtask

    task automatic test_addi();
        Bundle e;
        e = '{sel: 6'b010011, rs1: 5'd2, rs2: 5'd0, rd: 5'd1, imm: 32'hFFFFFFFB,
              useImm: 1'b1, regWrite: 1'b1, illegal: 1'b0};
        in_valid = 1'b1; in_instr = 32'hFFB10093; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || actB !== e) begin
            errors++;
            $display("[TB] FAIL addi valid=%b bundle=%h required valid=1 bundle=%h", out_valid, actB, e);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL addi_drain valid=%b required=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        Bundle eSub;
        Bundle eSrai;
        eSub  = '{sel: 6'b100100, rs1: 5'd1, rs2: 5'd2, rd: 5'd3, imm: 32'd0,
                  useImm: 1'b0, regWrite: 1'b1, illegal: 1'b0};
        eSrai = '{sel: 6'b011011, rs1: 5'd6, rs2: 5'd0, rd: 5'd5, imm: 32'd3,
                  useImm: 1'b1, regWrite: 1'b1, illegal: 1'b0};
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h402081B3;
        tick();
        in_instr = 32'h40335293;
        checks++;
        if (out_valid !== 1'b1 || actB !== eSub || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_sub valid=%b ready=%b bundle=%h required 1 1 %h", out_valid, in_ready, actB, eSub);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || actB !== eSrai || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_srai valid=%b ready=%b bundle=%h required 1 1 %h", out_valid, in_ready, actB, eSrai);
        end
        tick();
    endtask

    task automatic test_backpressure();
        Bundle eXori;
        Bundle eOri;
        eXori = '{sel: 6'b010110, rs1: 5'd2, rs2: 5'd0, rd: 5'd3, imm: 32'h000000FF,
                  useImm: 1'b1, regWrite: 1'b1, illegal: 1'b0};
        eOri  = '{sel: 6'b010111, rs1: 5'd6, rs2: 5'd0, rd: 5'd4, imm: 32'h00000005,
                  useImm: 1'b1, regWrite: 1'b1, illegal: 1'b0};
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0FF14193;
        tick();
        in_instr = 32'h00536213;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || actB !== eXori) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d valid=%b ready=%b bundle=%h required 1 0 %h",
                         c, out_valid, in_ready, actB, eXori);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_ready got=%b required=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || actB !== eOri) begin
            errors++;
            $display("[TB] FAIL pending_load valid=%b bundle=%h required 1 %h", out_valid, actB, eOri);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [31:0] bad[2];
        bad = '{32'h40009093, 32'h00002083};
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_instr = bad[k];
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || illegal !== 1'b1 || aluSelect !== 6'd0 || reg_write !== 1'b0
                || use_imm !== 1'b0 || imm !== 32'd0 || rd !== 5'd1) begin
                errors++;
                $display("[TB] FAIL illegal_%0d valid=%b ill=%b sel=%b wr=%b ui=%b imm=%h rd=%0d required 1 1 000000 0 0 0 1",
                         k, out_valid, illegal, aluSelect, reg_write, use_imm, imm, rd);
            end
        end
        tick();
    endtask

    task automatic test_x0();
        Bundle e;
        e = '{sel: 6'b011100, rs1: 5'd1, rs2: 5'd2, rd: 5'd0, imm: 32'd0,
              useImm: 1'b0, regWrite: 1'b0, illegal: 1'b0};
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00208033;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || actB !== e) begin
            errors++;
            $display("[TB] FAIL write_x0 valid=%b bundle=%h required 1 %h", out_valid, actB, e);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int pass = 0; pass < 2; pass++) begin
            out_ready = 1'b0;
            in_valid = 1'b1; in_instr = 32'h00208133;
            tick();
            // pass 0: held entry, pass 1: consumer ready so in_ready is high but input must still drop
            out_ready = (pass == 1);
            flush = 1'b1; in_instr = 32'h0FF37393;
            #1;
            checks++;
            if (in_ready !== (pass == 1)) begin
                errors++;
                $display("[TB] FAIL flush_ready_%0d got=%b required=%b", pass, in_ready, pass == 1);
            end
            tick();
            flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL flush_drop_%0d_%0d valid=%b required=0", pass, c, out_valid);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00A00513;
        tick();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || aluSelect !== 6'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset valid=%b sel=%b ready=%b required 0 000000 1", out_valid, aluSelect, in_ready);
        end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_random();
        Bundle       q[$];
        Bundle       e;
        Bundle       a;
        logic [31:0] r;
        logic [6:0]  f7;
        logic        acc;
        logic        cons;
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            case ($urandom_range(0, 4))
                0, 1: r[6:0] = 7'h13;
                2, 3: r[6:0] = 7'h33;
                default: ;
            endcase
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = r[31:25];
            endcase
            r[31:25] = f7;
            in_instr  = r;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (in_ready !== (q.size() == 0 || out_ready) || out_valid !== (q.size() != 0)) begin
                errors++;
                $display("[TB] FAIL rand_hs_%0d ready=%b valid=%b required %b %b",
                         n, in_ready, out_valid, q.size() == 0 || out_ready, q.size() != 0);
            end
            if (q.size() != 0) begin
                e = q[0];
                a = actB;
                if (e.illegal) begin
                    e.rs2 = '0;
                    a.rs2 = '0;
                end
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("[TB] FAIL rand_bundle_%0d got=%h required=%h", n, a, e);
                end
            end
            acc  = in_valid && !flush && (q.size() == 0 || out_ready);
            cons = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back(refDecode(in_instr));
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_x0();
        test_flush();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
Registered decode stage that sits in front of the integer ALU and produces its 6-bit aluSelect codes. It accepts 32-bit RV32I OP and OP-IMM instructions through a valid/ready handshake. It extracts the register indices and the immediate, and presents one registered decoded bundle to the execute stage with full backpressure and flush support.

Parameters:
XLEN, 32, datapath and immediate width.
SEL_W, 6, width of the aluSelect code.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  instruction word present.
in_ready  output  1  stage can accept an instruction this cycle.
in_instr  input  32  RV32I instruction word.
flush  input  1  discard the held entry and any incoming entry.
out_valid  output  1  decoded bundle valid.
out_ready  input  1  execute stage consumes the bundle.
aluSelect  output  SEL_W  ALU operation code.
rs1  output  5  source register 1 index.
rs2  output  5  source register 2 index; 0 for OP-IMM.
rd  output  5  destination register index.
imm  output  XLEN  operand-B immediate.
use_imm  output  1  1 selects imm as ALU operand b; 0 selects rs2 data.
reg_write  output  1  write rd with the ALU result.
illegal  output  1  instruction not decodable by this stage.

Behaviour:
- Reset (asynchronous, active-high; already decided): every output register cleared.
  - out_valid=0, aluSelect=0, rs1=rs2=rd=0, imm=0, use_imm=0, reg_write=0, illegal=0.
  - in_ready reads 1 as soon as reset deasserts.
- Single-entry pipeline register.
  - in_ready = !out_valid | out_ready (combinational).
  - Load occurs when in_valid & in_ready & !flush.
  - Latency: exactly 1 cycle from accepted input to out_valid.
  - Same-cycle consume and load is allowed, giving full throughput of one instruction per cycle.
- Hold rule: while out_valid & !out_ready, all outputs stay stable and in_ready=0.
- Consume with no new load: out_valid goes to 0 on the next edge. Payload fields keep their last value (don't-care).
- flush: synchronous, highest priority.
  - out_valid goes to 0 on the next edge.
  - The same-cycle input is dropped, even if in_valid=1.
  - in_ready still follows the formula above.
- Field extraction (from in_instr): opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- OP-IMM (opcode 0010011): use_imm=1, rs2=0.
  - funct3 000/010/011/100/110/111 map to ADDI 010011, SLTI 010100, SLTIU 010101, XORI 010110, ORI 010111, ANDI 011000.
  - For these, imm = sign-extended instr[31:20].
  - funct3 001 with funct7=0000000 is SLLI 011001.
  - funct3 101 with funct7=0000000 is SRLI 011010; with funct7=0100000 it is SRAI 011011.
  - For shifts, imm = zero-extended instr[24:20].
- OP (opcode 0110011): use_imm=0, imm=0.
  - funct7=0000000, funct3 000..111 map to ADD 011100, SLL 011101, SLT 011110, SLTU 011111, XOR 100000, SRL 100001, OR 100010, AND 100011.
  - funct7=0100000 with funct3 000 is SUB 100100; with funct3 101 it is SRA 100101.
- Illegal: any other opcode, funct7, or funct3 combination.
  - illegal=1, aluSelect=000000, reg_write=0, use_imm=0, imm=0.
  - The entry still completes the handshake; out_valid=1 as normal.
- reg_write = legal & (rd != 0). Writes to x0 are suppressed at decode.
- Reset asserted mid-hold: the entry is lost immediately and out_valid=0 asynchronously.

Test Plan:
1. ADDI: reset, then in_instr=0xFFB10093 (addi x1,x2,-5) with in_valid=1 and out_ready=1 → next cycle: out_valid=1, aluSelect=010011, rs1=2, rd=1, imm=0xFFFFFFFB, use_imm=1, reg_write=1, illegal=0.
2. SUB then SRAI back-to-back: 0x402081B3 then 0x40335293 on consecutive cycles → consecutive outputs:
   - SUB: aluSelect=100100, rs1=1, rs2=2, rd=3, use_imm=0.
   - SRAI: aluSelect=011011, rs1=6, rd=5, imm=0x00000003.
   - in_ready stays 1 throughout.
3. Backpressure: hold out_ready=0 for 3 cycles after one accept → in_ready=0 and outputs stable for those 3 cycles. A pending in_valid is not consumed until out_ready=1.
4. Illegal: in_instr=0x40009093 (slli with funct7=0100000) → illegal=1, aluSelect=000000, reg_write=0, out_valid=1. A load opcode 0x00002083 gives the same response.
5. Write to x0: add x0,x1,x2 = 0x00208033 → aluSelect=011100, reg_write=0, illegal=0.
6. flush and reset:
   - Assert flush with a held entry and in_valid=1 → out_valid=0 next cycle, and the incoming instruction never appears.
   - Assert reset mid-hold → out_valid=0 immediately, without waiting for a clock edge.
